data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
MEM-stage data-memory access controller. Sits between the EX/MEM pipeline register and the SDRAM/bus port.
- Turns the LOAD or STORE in instr_m into a single word-aligned bus transaction with byte enables.
- Sign- or zero-extends load data.
- Produces mem_access_done, which the hazard controller uses to hold the EX/MEM and MEM/WB stages while an access is outstanding.

Parameters:
TIMEOUT_CYC, 256, bus cycles to wait for bus_ack before aborting with bus_err
ADDR_W, 32, byte address width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
instr_m  in  instr_t  MEM-stage instruction (opcode, funct3 used)
addr_m  in  ADDR_W  effective byte address from ALU
store_data_m  in  32  store data, already forwarded
sdram_init_done  in  1  memory ready; no request is issued while low
bus_req  out  1  request valid
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word address, bits [1:0] = 0
bus_wdata  out  32  lane-shifted store data
bus_be  out  4  byte enables
bus_gnt  in  1  request accepted this cycle
bus_ack  in  1  access complete; bus_rdata valid for reads
bus_rdata  in  32  read word
load_data  out  32  extended load result, valid with mem_access_done
mem_access_done  out  1  one-cycle pulse: access finished
misalign  out  1  pulse with done: access was misaligned, not issued
bus_err  out  1  pulse with done: timeout abort

Behaviour:
- Reset: asynchronous on rst high. State = IDLE. All outputs 0. Timeout counter = 0.
- Access detection: access = opcode LOAD or STORE. Width comes from funct3:
  - LB/SB = 0, LH/SH = 1, LW/SW = 2, LBU = 4, LHU = 5.
  - Any other funct3 is treated as a word access.
- Alignment: half requires addr[0] = 0; word requires addr[1:0] = 0.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE → DONE when access and misaligned. Sets misalign; no bus activity.
  - IDLE → REQ when access, aligned and sdram_init_done. In the same cycle, register bus_we, bus_addr, bus_be and bus_wdata.
  - IDLE stays in IDLE when there is no access or sdram_init_done = 0.
  - REQ: bus_req = 1, fields stable. On bus_gnt → WAIT. If bus_gnt and bus_ack arrive in the same cycle → DONE directly.
  - WAIT: bus_req = 0. On bus_ack → DONE; latch the extended read data into load_data.
  - REQ/WAIT timeout: the counter increments each cycle in REQ or WAIT. When it reaches TIMEOUT_CYC-1 with no ack → DONE with bus_err = 1, load_data = 0.
  - DONE: mem_access_done = 1 for exactly this cycle → IDLE. The pipeline advances at the end of this cycle. instr_m is new in the next IDLE cycle, so the same instruction is never reissued.
- Latency: an aligned access with gnt and ack in the same cycle as REQ has done 2 cycles after instr_m arrives in IDLE. Each extra wait cycle adds 1.
- Byte lanes (little-endian), with lane = addr[1:0]:
  - SB: be = 1 << lane; wdata = {4{byte}}.
  - SH: be = 0011 or 1100 by addr[1]; wdata = {2{half}}.
  - SW: be = 1111.
  - Loads: be = 1111.
- Load extension: select the byte or half from bus_rdata by lane. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Outputs outside DONE: load_data holds its last value. misalign, bus_err and mem_access_done are 0.
- Mid-operation: instr_m is sampled only in IDLE. A change while in REQ/WAIT is ignored.
- Reset mid-transaction: returns immediately to IDLE with bus_req dropped. A late bus_ack in IDLE is ignored.
- Non-memory instruction: done stays 0. The hazard controller does not stall on non-memory opcodes.

Decomposition:
- Add to defines package:
  - mem_state_t enum: IDLE, REQ, WAIT, DONE.
  - mem_width_t: BYTE, HALF, WORD.
  - funct3 constants LB_F3..LHU_F3 and SB_F3..SW_F3.
- One combinational sub-module, mem_lane_align:
  - computes be and shifted wdata from width/addr/data;
  - extracts and extends load data from rdata/addr/funct3.
- The FSM and timeout counter stay in data_mem_ctrl.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt+ack in REQ cycle → bus_addr 0x100, be 1111, wdata 0xDEADBEEF, done pulse 2 cycles after entry.
- LB addr 0x203, rdata 0x80FF_0000, ack 3 cycles after gnt → load_data 0xFFFFFF80, done one cycle after ack. LBU same → 0x00000080.
- SH addr 0x402, data 0x0000_1234 → be 1100, wdata 0x12341234. LH addr 0x401 → misalign = 1, done next cycle, bus_req never asserted.
- sdram_init_done = 0 with LW pending → stays IDLE, no req, no done. Raise it → normal access completes.
- TIMEOUT_CYC = 8, gnt given, ack withheld → bus_err and done after 8 REQ/WAIT cycles, load_data = 0.
- rst pulsed while in WAIT → bus_req = 0, state IDLE. Stray ack next cycle → no done.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package data_mem_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] LB_F3  = 3'd0;
  localparam logic [2:0] LH_F3  = 3'd1;
  localparam logic [2:0] LW_F3  = 3'd2;
  localparam logic [2:0] LBU_F3 = 3'd4;
  localparam logic [2:0] LHU_F3 = 3'd5;
  localparam logic [2:0] SB_F3  = 3'd0;
  localparam logic [2:0] SH_F3  = 3'd1;
  localparam logic [2:0] SW_F3  = 3'd2;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;

  typedef enum logic [1:0] {BYTE, HALF, WORD} mem_width_t;

  // Access width from funct3; unknown encodings fall back to a word access.
  function automatic mem_width_t decode_width(input logic [2:0] f3, input logic is_store);
    mem_width_t w;
    w = WORD;
    if (is_store) begin
      case (f3)
        SB_F3:   w = BYTE;
        SH_F3:   w = HALF;
        SW_F3:   w = WORD;
        default: w = WORD;
      endcase
    end else begin
      case (f3)
        LB_F3, LBU_F3: w = BYTE;
        LH_F3, LHU_F3: w = HALF;
        LW_F3:         w = WORD;
        default:       w = WORD;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/acknowledge data bus between the MEM-stage controller and memory.
interface data_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
) ();
  import data_mem_ctrl_pkg::*;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [BE_W-1:0]   bus_be;
  logic              bus_gnt;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_gnt, bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_gnt, bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering for stores and extraction/extension for loads.
module mem_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  mem_width_t        st_width,
  input  logic [1:0]        st_lane,
  input  logic [DATA_W-1:0] st_data,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] wdata,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_lane,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate the datum across lanes and enable only the target bytes.
  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    case (st_width)
      BYTE: begin
        be    = 4'b0001 << st_lane;
        wdata = {4{st_data[7:0]}};
      end
      HALF: begin
        be    = st_lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = st_data;
      end
    endcase
  end

  // Load side: pick the addressed byte/half and extend per funct3.
  always_comb begin
    ld_byte = rdata[7:0];
    case (ld_lane)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_lane[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      LB_F3:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LBU_F3:  ld_data = {24'h0, ld_byte};
      LH_F3:   ld_data = {{16{ld_half[15]}}, ld_half};
      LHU_F3:  ld_data = {16'h0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory controller: one bus transaction per LOAD/STORE, with timeout.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  instr_t            instr_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [DATA_W-1:0] store_data_m,
  input  logic              sdram_init_done,
  data_mem_ctrl_if.master   bus,
  output logic [DATA_W-1:0] load_data,
  output logic              mem_access_done,
  output logic              misalign,
  output logic              bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;

  logic              is_load_c, is_store_c, access_c, misaligned_c;
  mem_width_t        width_c;
  logic [BE_W-1:0]   be_c;
  logic [DATA_W-1:0] wdata_c, ext_c;
  logic              instr_unused_c;

  assign is_load_c  = (instr_m.opcode == OP_LOAD);
  assign is_store_c = (instr_m.opcode == OP_STORE);
  assign access_c   = is_load_c | is_store_c;
  assign width_c    = decode_width(instr_m.funct3, is_store_c);
  assign misaligned_c = ((width_c == HALF) && addr_m[0]) ||
                        ((width_c == WORD) && (addr_m[1:0] != 2'b00));
  assign instr_unused_c = ^{instr_m.funct7, instr_m.rs2, instr_m.rs1, instr_m.rd};

  mem_lane_align u_lane_align (
    .st_width  (width_c),
    .st_lane   (addr_m[1:0]),
    .st_data   (store_data_m),
    .be        (be_c),
    .wdata     (wdata_c),
    .ld_funct3 (f3_q),
    .ld_lane   (lane_q),
    .rdata     (bus.bus_rdata),
    .ld_data   (ext_c)
  );

  // Next-state, timeout counter and next registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    req_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    load_d  = load_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_c) begin
          if (misaligned_c) begin
            state_d = DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else if (sdram_init_done) begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = is_store_c;
            addr_d  = {addr_m[ADDR_W-1:2], 2'b00};
            wdata_d = wdata_c;
            be_d    = is_store_c ? be_c : 4'b1111;
            f3_d    = instr_m.funct3;
            lane_d  = addr_m[1:0];
          end
        end
      end
      REQ, WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        req_d = (state_q == REQ);
        // An ack only counts in REQ when it arrives together with the grant.
        if (bus.bus_ack && ((state_q == WAIT) || bus.bus_gnt)) begin
          state_d = DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) begin
            load_d = ext_c;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          load_d  = '0;
        end else if ((state_q == REQ) && bus.bus_gnt) begin
          state_d = WAIT;
          req_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      lane_q  <= '0;
      load_q  <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      load_q  <= load_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign bus.bus_req      = req_q;
  assign bus.bus_we       = we_q;
  assign bus.bus_addr     = addr_q;
  assign bus.bus_wdata    = wdata_q;
  assign bus.bus_be       = be_q;
  assign load_data        = load_q;
  assign mem_access_done  = done_q;
  assign misalign         = mis_q;
  assign bus_err          = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed, table-driven bench for data_mem_ctrl with a simple bus responder.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TO_CYC = 8;
  localparam logic [6:0]  OP_NOP = 7'h13;
  localparam int          NVEC   = 16;

  logic        clk = 1'b0;
  logic        rst;
  instr_t      instr_m;
  logic [31:0] addr_m;
  logic [31:0] store_data_m;
  logic        sdram_init_done;
  logic [31:0] load_data;
  logic        mem_access_done, misalign, bus_err;

  data_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus_if ();

  data_mem_ctrl #(.TIMEOUT_CYC(TO_CYC), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_m         (instr_m),
    .addr_m          (addr_m),
    .store_data_m    (store_data_m),
    .sdram_init_done (sdram_init_done),
    .bus             (bus_if),
    .load_data       (load_data),
    .mem_access_done (mem_access_done),
    .misalign        (misalign),
    .bus_err         (bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr, sdata, rdata;
    int          gnt_wait;   // REQ cycles before gnt is given
    int          ack_wait;   // cycles after gnt until ack; -1 = never
    int          lat;        // cycles from IDLE entry to done
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_mis, exp_err;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic instr_t mk_instr(input logic [6:0] op, input logic [2:0] f3);
    instr_t i;
    i = '0;
    i.opcode = op;
    i.funct3 = f3;
    return i;
  endfunction

  function automatic vec_t mv(input string n, input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                              input int gw, input int aw, input int lat,
                              input logic [31:0] ea, input logic [3:0] be, input logic [31:0] wd,
                              input logic mis, input logic err, input logic [31:0] ld);
    vec_t r;
    r.name = n; r.op = op; r.f3 = f3; r.addr = a; r.sdata = sd; r.rdata = rd;
    r.gnt_wait = gw; r.ack_wait = aw; r.lat = lat;
    r.exp_addr = ea; r.exp_be = be; r.exp_wdata = wd;
    r.exp_mis = mis; r.exp_err = err; r.exp_load = ld;
    return r;
  endfunction

  // Apply one instruction in IDLE, act as the bus slave, and check the outcome.
  task automatic run_vec(input vec_t t);
    int req_n, gnt_c, done_c;
    logic [31:0] ld_s;
    logic mis_s, err_s, req_s;
    req_n = 0; gnt_c = -1; done_c = -1;
    ld_s = '0; mis_s = 1'b0; err_s = 1'b0; req_s = 1'b0;
    instr_m = mk_instr(t.op, t.f3);
    addr_m = t.addr;
    store_data_m = t.sdata;
    bus_if.bus_rdata = t.rdata;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus_if.bus_gnt = 1'b0;
      bus_if.bus_ack = 1'b0;
      if (mem_access_done) begin
        done_c = c;
        ld_s = load_data; mis_s = misalign; err_s = bus_err; req_s = bus_if.bus_req;
        break;
      end
      if (bus_if.bus_req) begin
        if (req_n == 0) begin
          chk($sformatf("%s.addr", t.name), bus_if.bus_addr, t.exp_addr);
          chk($sformatf("%s.be", t.name), 32'(bus_if.bus_be), 32'(t.exp_be));
          chk($sformatf("%s.we", t.name), 32'(bus_if.bus_we), 32'(t.op == OP_STORE));
          if (t.op == OP_STORE)
            chk($sformatf("%s.wdata", t.name), bus_if.bus_wdata, t.exp_wdata);
        end
        if (req_n >= t.gnt_wait) begin
          bus_if.bus_gnt = 1'b1;
          gnt_c = c;
          if (t.ack_wait == 0) bus_if.bus_ack = 1'b1;
        end
        req_n++;
      end else if (gnt_c > 0 && t.ack_wait > 0 && (c - gnt_c) == t.ack_wait) begin
        bus_if.bus_ack = 1'b1;
      end
    end
    instr_m = mk_instr(OP_NOP, 3'd0);
    bus_if.bus_gnt = 1'b0;
    bus_if.bus_ack = 1'b0;
    chk($sformatf("%s.latency", t.name), 32'(done_c), 32'(t.lat));
    chk($sformatf("%s.misalign", t.name), 32'(mis_s), 32'(t.exp_mis));
    chk($sformatf("%s.bus_err", t.name), 32'(err_s), 32'(t.exp_err));
    chk($sformatf("%s.load_data", t.name), ld_s, t.exp_load);
    chk($sformatf("%s.req_in_done", t.name), 32'(req_s), 32'd0);
    chk($sformatf("%s.req_issued", t.name), 32'(req_n > 0), 32'(!t.exp_mis));
    @(negedge clk);
    chk($sformatf("%s.done_pulse", t.name), 32'(mem_access_done), 32'd0);
    chk($sformatf("%s.flags_clear", t.name), 32'({misalign, bus_err}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mv("sw_100",    OP_STORE, SW_F3,  32'h100, 32'hDEADBEEF, 32'h0,        0,  0, 2, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 0, 32'h0);
    vecs[1]  = mv("lb_203",    OP_LOAD,  LB_F3,  32'h203, 32'h0,        32'h80FF0000, 0,  3, 5, 32'h200, 4'b1111, 32'h0,        0, 0, 32'hFFFFFF80);
    vecs[2]  = mv("lbu_203",   OP_LOAD,  LBU_F3, 32'h203, 32'h0,        32'h80FF0000, 0,  3, 5, 32'h200, 4'b1111, 32'h0,        0, 0, 32'h00000080);
    vecs[3]  = mv("sh_402",    OP_STORE, SH_F3,  32'h402, 32'h00001234, 32'h0,        0,  0, 2, 32'h400, 4'b1100, 32'h12341234, 0, 0, 32'h00000080);
    vecs[4]  = mv("lh_401",    OP_LOAD,  LH_F3,  32'h401, 32'h0,        32'h0,        0,  0, 1, 32'h0,   4'b0000, 32'h0,        1, 0, 32'h00000080);
    vecs[5]  = mv("lh_206",    OP_LOAD,  LH_F3,  32'h206, 32'h0,        32'h80010000, 2,  0, 4, 32'h204, 4'b1111, 32'h0,        0, 0, 32'hFFFF8001);
    vecs[6]  = mv("lhu_206",   OP_LOAD,  LHU_F3, 32'h206, 32'h0,        32'h80011234, 0,  1, 3, 32'h204, 4'b1111, 32'h0,        0, 0, 32'h00008001);
    vecs[7]  = mv("lw_010",    OP_LOAD,  LW_F3,  32'h010, 32'h0,        32'hCAFEF00D, 0,  0, 2, 32'h010, 4'b1111, 32'h0,        0, 0, 32'hCAFEF00D);
    vecs[8]  = mv("sb_031",    OP_STORE, SB_F3,  32'h031, 32'h000000A5, 32'h0,        0,  0, 2, 32'h030, 4'b0010, 32'hA5A5A5A5, 0, 0, 32'hCAFEF00D);
    vecs[9]  = mv("sb_060",    OP_STORE, SB_F3,  32'h060, 32'h11223344, 32'h0,        0,  0, 2, 32'h060, 4'b0001, 32'h44444444, 0, 0, 32'hCAFEF00D);
    vecs[10] = mv("sh_060",    OP_STORE, SH_F3,  32'h060, 32'hABCD5678, 32'h0,        0,  0, 2, 32'h060, 4'b0011, 32'h56785678, 0, 0, 32'hCAFEF00D);
    vecs[11] = mv("lw_022",    OP_LOAD,  LW_F3,  32'h022, 32'h0,        32'h0,        0,  0, 1, 32'h0,   4'b0000, 32'h0,        1, 0, 32'hCAFEF00D);
    vecs[12] = mv("lf3_050",   OP_LOAD,  3'd3,   32'h050, 32'h0,        32'h12345678, 0,  0, 2, 32'h050, 4'b1111, 32'h0,        0, 0, 32'h12345678);
    vecs[13] = mv("to_wait",   OP_LOAD,  LW_F3,  32'h040, 32'h0,        32'h77777777, 0, -1, 9, 32'h040, 4'b1111, 32'h0,        0, 1, 32'h0);
    vecs[14] = mv("to_nognt",  OP_STORE, SW_F3,  32'h044, 32'h5555AAAA, 32'h0,        99,-1, 9, 32'h044, 4'b1111, 32'h5555AAAA, 0, 1, 32'h0);
    vecs[15] = mv("sh_403",    OP_STORE, SH_F3,  32'h403, 32'h0000BEEF, 32'h0,        0,  0, 1, 32'h0,   4'b0000, 32'h0,        1, 0, 32'h0);

    rst = 1'b1;
    instr_m = mk_instr(OP_NOP, 3'd0);
    addr_m = '0;
    store_data_m = '0;
    sdram_init_done = 1'b1;
    bus_if.bus_gnt = 1'b0;
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset.req", 32'(bus_if.bus_req), 32'd0);
    chk("reset.flags", 32'({mem_access_done, misalign, bus_err, bus_if.bus_we}), 32'd0);
    chk("reset.load_data", load_data, 32'd0);
    chk("reset.addr", bus_if.bus_addr, 32'd0);
    chk("reset.be", 32'(bus_if.bus_be), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("nop.done", 32'(mem_access_done), 32'd0);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Memory not ready: LW must wait in IDLE without a request.
    sdram_init_done = 1'b0;
    instr_m = mk_instr(OP_LOAD, LW_F3);
    addr_m = 32'h80;
    bus_if.bus_rdata = 32'h0BADF00D;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("noinit.req", 32'(bus_if.bus_req), 32'd0);
      chk("noinit.done", 32'(mem_access_done), 32'd0);
    end
    sdram_init_done = 1'b1;
    run_vec(mv("init_lw", OP_LOAD, LW_F3, 32'h080, 32'h0, 32'h0BADF00D, 0, 0, 2,
               32'h080, 4'b1111, 32'h0, 0, 0, 32'h0BADF00D));

    // Instruction changes while the request is outstanding must be ignored.
    instr_m = mk_instr(OP_STORE, SW_F3);
    addr_m = 32'hA0;
    store_data_m = 32'h01020304;
    @(negedge clk);
    chk("midop.req", 32'(bus_if.bus_req), 32'd1);
    instr_m = mk_instr(OP_LOAD, LB_F3);
    addr_m = 32'h203;
    store_data_m = 32'hFFFFFFFF;
    @(negedge clk);
    chk("midop.addr", bus_if.bus_addr, 32'hA0);
    chk("midop.be", 32'(bus_if.bus_be), 32'hF);
    chk("midop.we", 32'(bus_if.bus_we), 32'd1);
    chk("midop.wdata", bus_if.bus_wdata, 32'h01020304);
    bus_if.bus_gnt = 1'b1;
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_gnt = 1'b0;
    bus_if.bus_ack = 1'b0;
    instr_m = mk_instr(OP_NOP, 3'd0);
    chk("midop.done", 32'(mem_access_done), 32'd1);
    @(negedge clk);
    chk("midop.no_reissue", 32'({mem_access_done, bus_if.bus_req}), 32'd0);

    // Reset while waiting for ack, then a stray ack must not complete anything.
    instr_m = mk_instr(OP_LOAD, LW_F3);
    addr_m = 32'h90;
    bus_if.bus_rdata = 32'h55555555;
    @(negedge clk);
    chk("rstwait.req", 32'(bus_if.bus_req), 32'd1);
    bus_if.bus_gnt = 1'b1;
    @(negedge clk);
    bus_if.bus_gnt = 1'b0;
    chk("rstwait.in_wait", 32'(dut.state_q), 32'(WAIT));
    rst = 1'b1;
    #1;
    chk("rstwait.state", 32'(dut.state_q), 32'(IDLE));
    chk("rstwait.req_drop", 32'(bus_if.bus_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    instr_m = mk_instr(OP_NOP, 3'd0);
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    chk("stray_ack.done", 32'(mem_access_done), 32'd0);
    chk("stray_ack.load", load_data, 32'd0);
    @(negedge clk);
    chk("stray_ack.done2", 32'(mem_access_done), 32'd0);
    chk("stray_ack.state", 32'(dut.state_q), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
